// File: rtl/onehot_decoder_seq.sv
// Registered N-to-2^N select decoder with a valid/ready code input, a hold register and
// a self-running scan mode. Optional thermometer decode is built in with `define DEC_THERM_EN.
module onehot_decoder_seq #(
  parameter int IN_W  = 3,
  parameter int DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in,
  input  logic                   scan_en,
  input  logic                   clr,
`ifdef DEC_THERM_EN
  input  logic                   therm,
`endif
  output logic [(1<<IN_W)-1:0]   out,
  output logic                   out_valid,
  output logic [IN_W-1:0]        out_idx,
  output logic [1:0]             dbg_state
);

  localparam int OUT_W = 1 << IN_W;
  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   code_q, code_d;
  logic [IN_W-1:0]   idx_q, idx_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [IN_W-1:0]   out_idx_q, out_idx_d;
  logic              therm_sel;
  logic              accept;

`ifdef DEC_THERM_EN
  assign therm_sel = therm;
`else
  assign therm_sel = 1'b0;
`endif

  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] k, input logic th);
    logic [OUT_W-1:0] d;
    d = '0;
    for (int i = 0; i < OUT_W; i++) begin
      d[i] = th ? (i <= int'(k)) : (i == int'(k));
    end
    return d;
  endfunction

  // Handshake: a code transfers on any cycle where in_valid && in_ready.
  // in_ready is combinational so a scan request blocks acceptance in the same cycle.
  assign in_ready = (state_q != ST_SCAN) && !scan_en;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    out_d       = '0;
    out_valid_d = 1'b0;
    out_idx_d   = '0;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (scan_en) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          dwell_d = '0;
        end else if (accept) begin
          state_d = ST_HOLD;
          code_d  = in;
        end else if (state_q == ST_HOLD && clr) begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!scan_en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          dwell_d = '0;
        end else if (dwell_q == DW'(DWELL - 1)) begin
          dwell_d = '0;
          idx_d   = idx_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they land on the same edge as it.
    case (state_d)
      ST_HOLD: begin
        out_d       = decode(code_d, therm_sel);
        out_valid_d = 1'b1;
        out_idx_d   = code_d;
      end
      ST_SCAN: begin
        out_d       = decode(idx_d, therm_sel);
        out_valid_d = 1'b1;
        out_idx_d   = idx_d;
      end
      default: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        out_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      idx_q       <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: default instance (IN_W=3, DWELL=4) and a
// fast-scan instance (IN_W=2, DWELL=1); thermometer steps run when DEC_THERM_EN is defined.
module tb_onehot_decoder_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       scan_en;
  logic       clr;
  logic       therm;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [1:0] dbg_state;

  logic       d1_in_valid;
  logic       d1_in_ready;
  logic [1:0] d1_in_code;
  logic       d1_scan_en;
  logic       d1_clr;
  logic [3:0] d1_out;
  logic       d1_out_valid;
  logic [1:0] d1_out_idx;
  logic [1:0] d1_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;

  onehot_decoder_seq #(.IN_W(3), .DWELL(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_code),
    .scan_en   (scan_en),
    .clr       (clr),
`ifdef DEC_THERM_EN
    .therm     (therm),
`endif
    .out       (out),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .dbg_state (dbg_state)
  );

  onehot_decoder_seq #(.IN_W(2), .DWELL(1)) u_d1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
    .in        (d1_in_code),
    .scan_en   (d1_scan_en),
    .clr       (d1_clr),
`ifdef DEC_THERM_EN
    .therm     (1'b0),
`endif
    .out       (d1_out),
    .out_valid (d1_out_valid),
    .out_idx   (d1_out_idx),
    .dbg_state (d1_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = '0; scan_en = 1'b0; clr = 1'b0; therm = 1'b0;
    d1_in_valid = 1'b0; d1_in_code = '0; d1_scan_en = 1'b0; d1_clr = 1'b0;
    step();
    step();
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_idx", 32'(out_idx), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // single handshake
    in_code = 3'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("hs_out", 32'(out), 32'h20);
    chk("hs_out_valid", 32'(out_valid), 32'h1);
    chk("hs_out_idx", 32'(out_idx), 32'h5);
    chk("hs_state", 32'(dbg_state), 32'(S_HOLD));

    // back-to-back codes, no gap
    in_code = 3'd0; in_valid = 1'b1;
    step();
    chk("b2b_0", 32'(out), 32'h01);
    in_code = 3'd7;
    step();
    chk("b2b_7", 32'(out), 32'h80);
    chk("b2b_7_idx", 32'(out_idx), 32'h7);
    in_valid = 1'b0;

    // clr drops the held channel
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_out", 32'(out), 32'h00);
    chk("clr_out_valid", 32'(out_valid), 32'h0);
    chk("clr_state", 32'(dbg_state), 32'(S_IDLE));

    // clr together with a new code: the code wins
    in_code = 3'd1; in_valid = 1'b1;
    step();
    clr = 1'b1; in_code = 3'd2;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_code_out", 32'(out), 32'h04);
    chk("clr_code_valid", 32'(out_valid), 32'h1);

    // scan sweep: 40 cycles, 4 per channel, wraps
    for (int c = 0; c < 40; c++) begin
      exp_v = 8'h01 << ((c / 4) % 8);
      exp_q.push_back(exp_v);
    end
    scan_en = 1'b1;
    #1;
    chk("scan_req_in_ready", 32'(in_ready), 32'h0);
    step();
    for (int c = 0; c < 40; c++) begin
      exp_v = exp_q.pop_front();
      chk($sformatf("scan_out_c%0d", c), 32'(out), 32'(exp_v));
      chk("scan_in_ready", 32'(in_ready), 32'h0);
      if (c == 10) begin
        in_valid = 1'b1; in_code = 3'd6;
      end
      step();
      in_valid = 1'b0;
    end
    scan_en = 1'b0;
    step();
    chk("scan_exit_out", 32'(out), 32'h00);
    chk("scan_exit_state", 32'(dbg_state), 32'(S_IDLE));

    // re-enter, drop at idx 3
    scan_en = 1'b1;
    step();
    chk("reenter_out", 32'(out), 32'h01);
    for (int i = 0; i < 12; i++) step();
    chk("idx3_out", 32'(out), 32'h08);
    chk("idx3_out_idx", 32'(out_idx), 32'h3);
    chk("idx3_valid", 32'(out_valid), 32'h1);
    scan_en = 1'b0;
    step();
    chk("drop3_out", 32'(out), 32'h00);
    chk("drop3_valid", 32'(out_valid), 32'h0);
    chk("drop3_idx", 32'(out_idx), 32'h0);
    chk("drop3_state", 32'(dbg_state), 32'(S_IDLE));

    // re-enter, reset at idx 6
    scan_en = 1'b1;
    step();
    chk("restart_out", 32'(out), 32'h01);
    chk("restart_state", 32'(dbg_state), 32'(S_SCAN));
    for (int i = 0; i < 24; i++) step();
    chk("idx6_out", 32'(out), 32'h40);
    chk("idx6_out_idx", 32'(out_idx), 32'h6);
    rst = 1'b1;
    step();
    chk("midrst_out", 32'(out), 32'h00);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_idx", 32'(out_idx), 32'h0);
    chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0; scan_en = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'h1);

    // DWELL=1, IN_W=2: advances every cycle
    d1_scan_en = 1'b1;
    step();
    chk("d1_c0", 32'(d1_out), 32'h1);
    step();
    chk("d1_c1", 32'(d1_out), 32'h2);
    step();
    chk("d1_c2", 32'(d1_out), 32'h4);
    step();
    chk("d1_c3", 32'(d1_out), 32'h8);
    chk("d1_c3_idx", 32'(d1_out_idx), 32'h3);
    step();
    chk("d1_c4", 32'(d1_out), 32'h1);
    step();
    chk("d1_c5", 32'(d1_out), 32'h2);
    chk("d1_c5_ready", 32'(d1_in_ready), 32'h0);
    chk("d1_c5_state", 32'(d1_dbg_state), 32'(S_SCAN));
    chk("d1_c5_valid", 32'(d1_out_valid), 32'h1);
    d1_scan_en = 1'b0;
    step();
    chk("d1_exit", 32'(d1_out), 32'h0);

`ifdef DEC_THERM_EN
    therm = 1'b1; in_code = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("therm_k2", 32'(out), 32'h07);
    therm = 1'b0;
    step();
    chk("therm_off_k2", 32'(out), 32'h04);
    therm = 1'b1; in_code = 3'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("therm_k7", 32'(out), 32'hFF);
    therm = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Registered, parametrised N-to-2^N decoder with a valid/ready input handshake, a hold register and an autonomous scan mode that walks the asserted output line through all channels with a programmable dwell. It drives select lines for multiplexed peripherals: digit strobes, bank enables and row selects. Software can latch a fixed channel, or let the block sweep every channel on its own.

## Interface
- IN_W, default 3: code width. Output width is 2**IN_W; legal range is 1..6.
- DWELL, default 4: cycles each channel stays asserted in scan mode; minimum 1.

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  code on `in` is valid
- in_ready  output  1  block accepts a code this cycle
- in  input  IN_W  binary channel code
- scan_en  input  1  level; request scan mode
- clr  input  1  pulse; drop the held channel
- therm  input  1  thermometer output select; port exists only with DEC_THERM_EN
- out  output  2**IN_W  registered decoded select lines
- out_valid  output  1  `out` carries a live selection
- out_idx  output  IN_W  index currently driven on `out`

## Operation
- States:
  - IDLE: out=0, out_valid=0.
  - HOLD: out=decode(code_q), out_valid=1.
  - SCAN: out=decode(idx_q), out_valid=1.
- in_ready = (state != SCAN) && !scan_en. This is combinational from the state and scan_en.
- IDLE/HOLD, in_valid && in_ready: code_q <= in; next state HOLD. A new code in HOLD replaces the old one with no gap cycle.
- IDLE/HOLD, scan_en=1: next state SCAN; idx_q <= 0; dwell_q <= 0. A concurrent in_valid is not accepted, because in_ready=0.
- HOLD, clr=1 with no accepted code: next state IDLE. If clr and an accepted code arrive together, the code wins.
- SCAN:
  - dwell_q counts 0..DWELL-1.
  - When dwell_q == DWELL-1: dwell_q <= 0 and idx_q <= idx_q+1, wrapping from 2**IN_W-1 to 0.
  - scan_en=0: next state IDLE, counters cleared. clr is ignored in SCAN.
- decode(k) is one-hot: bit k set. out_idx equals code_q in HOLD, idx_q in SCAN, and 0 in IDLE.
- Counter width is max(1, clog2(DWELL)). With DWELL=1 the index advances every cycle.

## Timing
- Reset values: state IDLE, out=0, out_valid=0, out_idx=0, code_q=0, idx_q=0, dwell_q=0. in_ready=1 once rst is low and scan_en is 0.
- Handshake to output: 1 cycle latency. The code accepted at edge T appears on out, out_valid and out_idx after edge T.
- scan_en rising: channel 0 is driven after the next edge. Each channel is then held exactly DWELL cycles.
- scan_en falling: out=0 and out_valid=0 after the next edge. The held code is not restored; the block returns to IDLE.
- rst mid-scan or mid-hold: all registers return to reset values on that edge. rst overrides every other input.
- out, out_valid and out_idx all update on the same edge; no output glitches by construction.

## Configuration
- DEC_THERM_EN defined:
  - Port `therm` exists.
  - When therm=1, decode(k) = bits k..0 set (thermometer). With IN_W=3: k=2 gives 8'b00000111; k=7 gives 8'hFF.
  - therm is sampled every cycle; a change takes effect on out after the next edge.
- DEC_THERM_EN undefined: port `therm` is absent and out is always one-hot.

## Test plan
- Reset, then handshake: rst high 2 cycles -> out=0, out_valid=0, in_ready=1. Then in=3'd5 with in_valid for 1 cycle -> next cycle out=8'b00100000, out_valid=1, out_idx=5.
- Back-to-back codes and clr:
  - in=3'd0 then 3'd7 on consecutive cycles -> out=8'h01, then 8'h80, no gap.
  - clr pulse -> out=0, out_valid=0 next cycle.
  - clr together with in=3'd2 -> out=8'h04.
- Scan with DWELL=4, IN_W=3:
  - Hold scan_en for 40 cycles -> out steps 8'h01, 8'h02, ..., 8'h80, 4 cycles each, then wraps to 8'h01.
  - in_ready=0 throughout; an in_valid pulse during scan leaves code_q unchanged.
- Scan exit and mid-scan reset:
  - Drop scan_en at idx 3 -> out=0 next cycle; state IDLE.
  - Re-enter scan -> restarts at 8'h01.
  - Assert rst at idx 6 -> all outputs reset on that edge.
- DWELL=1, IN_W=2: scan_en held for 6 cycles -> out=4'b0001, 0010, 0100, 1000, 0001, 0010.
- DEC_THERM_EN build: therm=1, in=3'd2 -> out=8'b00000111. Then set therm=0 -> out=8'b00000100 after the next edge.
